// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a combinational hit path and line refill FSM.
// Optional hit/miss performance counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module instruction_cache #(
    parameter int unsigned LineWords      = 4,
    parameter int unsigned LineCount      = 64,
    parameter logic [31:0] NopInstruction = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] read_address_i,
    output logic [31:0] read_data_o,
    output logic        read_valid_o,
    output logic        stall_o,
    input  logic        invalidate_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_address_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam int unsigned OffsW = $clog2(LineWords);
    localparam int unsigned IdxW  = $clog2(LineCount);
    localparam int unsigned TagW  = 32 - 2 - OffsW - IdxW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        REFILL  = 2'd2
    } state_e;

    state_e               state_r;
    logic [LineCount-1:0] valid_r;
    logic [TagW-1:0]      tag_mem_r  [LineCount];
    logic [31:0]          data_mem_r [LineCount][LineWords];
    logic [IdxW-1:0]      refill_idx_r;
    logic [TagW-1:0]      refill_tag_r;
    logic [OffsW-1:0]     cnt_r;
    logic                 pend_r;

    logic [OffsW-1:0]     offs_s;
    logic [IdxW-1:0]      idx_s;
    logic [TagW-1:0]      tag_s;
    logic                 hit_s;
    logic                 resp_fire_s;
    logic                 last_s;
    logic                 unused_addr_s;

    assign offs_s        = read_address_i[2 +: OffsW];
    assign idx_s         = read_address_i[2 + OffsW +: IdxW];
    assign tag_s         = read_address_i[31 -: TagW];
    assign unused_addr_s = ^read_address_i[1:0];

    // Hit detection: only a fully refilled, tagged line in IDLE may hit
    always_comb begin
        hit_s = 1'b0;
        if ((state_r == IDLE) && valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s) && !invalidate_i) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Fetch-side outputs, zero latency on a hit
    always_comb begin
        read_valid_o = hit_s;
        stall_o      = !hit_s;
        read_data_o  = NopInstruction;
        if (hit_s) begin
            read_data_o = data_mem_r[idx_s][offs_s];
        end else begin
            read_data_o = NopInstruction;
        end
    end

    // Refill response qualification
    always_comb begin
        resp_fire_s = (state_r == REFILL) && mem_resp_valid_i;
        last_s      = 1'b0;
        if (resp_fire_s && (cnt_r == OffsW'(LineWords - 1))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Control FSM: valid bits, refill bookkeeping and the memory request port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r           <= IDLE;
            valid_r           <= {LineCount{1'b0}};
            mem_req_valid_o   <= 1'b0;
            mem_req_address_o <= 32'h0000_0000;
            cnt_r             <= {OffsW{1'b0}};
            pend_r            <= 1'b0;
            refill_idx_r      <= {IdxW{1'b0}};
            refill_tag_r      <= {TagW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (invalidate_i) begin
                        valid_r <= {LineCount{1'b0}};
                    end else if (!hit_s) begin
                        refill_idx_r      <= idx_s;
                        refill_tag_r      <= tag_s;
                        valid_r[idx_s]    <= 1'b0;
                        mem_req_valid_o   <= 1'b1;
                        mem_req_address_o <= {tag_s, idx_s, {(OffsW + 2){1'b0}}};
                        state_r           <= REQUEST;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQUEST: begin
                    if (invalidate_i) begin
                        pend_r <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_o   <= 1'b0;
                        mem_req_address_o <= 32'h0000_0000;
                        cnt_r             <= {OffsW{1'b0}};
                        state_r           <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate_i) begin
                        pend_r <= 1'b1;
                    end
                    if (resp_fire_s) begin
                        cnt_r <= cnt_r + OffsW'(1);
                    end
                    // An invalidate seen at any point of the refill discards every line on completion
                    if (last_s) begin
                        if (pend_r || invalidate_i) begin
                            valid_r <= {LineCount{1'b0}};
                        end else begin
                            valid_r[refill_idx_r] <= 1'b1;
                        end
                        pend_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Data and tag storage, written only by refill responses
    always_ff @(posedge clk_i) begin
        if (resp_fire_s) begin
            data_mem_r[refill_idx_r][cnt_r] <= mem_resp_data_i;
        end
        if (last_s) begin
            tag_mem_r[refill_idx_r] <= refill_tag_r;
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    // Hit cycles and refill starts, both wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_o  <= 32'h0000_0000;
            miss_count_o <= 32'h0000_0000;
        end else begin
            if (hit_s) begin
                hit_count_o <= hit_count_o + 32'd1;
            end
            if ((state_r == IDLE) && !hit_s && !invalidate_i) begin
                miss_count_o <= miss_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache that sits directly upstream of the core's fetch stage.
- Serves the fetch PC (the core's icache read address) with a combinational hit path and returns the instruction word.
- On a miss, asserts stall and refills the full line from a backing memory through a valid/ready request and in-order response stream.
- Supports whole-cache invalidation for fence.i.

Parameters:
LineWords, 4, 32-bit words per line (power of two, >=2)
LineCount, 64, number of lines (power of two)
NopInstruction, 32'h00000013, word driven on read_data_o when not hitting

Ports:
clk_i  input  1  clock
rst_i  input  1  reset
read_address_i  input  32  fetch address from core (bits [1:0] ignored)
read_data_o  output  32  instruction word
read_valid_o  output  1  read_data_o holds cached data for read_address_i
stall_o  output  1  core must hold PC and treat fetched word as bubble
invalidate_i  input  1  single-cycle pulse: invalidate all lines
mem_req_valid_o  output  1  line refill request valid
mem_req_ready_i  input  1  memory accepts request
mem_req_address_o  output  32  line-aligned refill address
mem_resp_valid_i  input  1  response word valid
mem_resp_data_i  input  32  response word; words arrive in ascending order

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous, active-high.
- Address split:
  - word offset = [2+log2(LineWords)-1:2]
  - index = next log2(LineCount) bits
  - tag = remaining upper bits
- Storage: data array (LineCount x LineWords x 32), tag array, valid bit per line. Only the valid bits are reset.
- hit = state==IDLE && valid[index] && tag[index]==addr tag && !invalidate_i.
  - Hit: read_data_o = data word, read_valid_o=1, stall_o=0. Combinational, zero latency.
  - Otherwise: read_data_o=NopInstruction, read_valid_o=0, stall_o=1.
- Reset values: state IDLE; all valid bits 0; mem_req_valid_o=0; refill word counter 0; pending-invalidate 0. read_valid_o=0 and stall_o=1 while any valid bit is 0 for the addressed line.
- FSM states: IDLE, REQUEST, REFILL.
  - IDLE: on miss (and no invalidate_i), latch line base address (addr with offset bits cleared), clear valid[index], go REQUEST.
  - REQUEST: mem_req_valid_o=1, mem_req_address_o=latched base. Hold both stable until mem_req_ready_i. On handshake, counter=0 and go REFILL.
  - REFILL: each mem_resp_valid_i writes word[counter] of the latched line and increments the counter. On the last word (counter==LineWords-1):
    - write tag;
    - set valid unless an invalidate is pending;
    - clear pending;
    - go IDLE.
- mem_resp_valid_i outside REFILL is ignored.
- mem_req_address_o = 0 outside REQUEST.
- Fetch address changes during a refill (e.g. redirect) do not abort it. The new address is evaluated on return to IDLE.
- Minimum miss latency:
  - miss seen in cycle 0; REQUEST in cycle 1 (ready=1);
  - responses in cycles 2..LineWords+1;
  - hit in cycle LineWords+2 (cycle 6 with defaults).
- invalidate_i:
  - In IDLE: clear all valid bits at the clock edge; stall_o=1 that cycle.
  - In REQUEST/REFILL: set pending. The current refill completes, but its line is left invalid and all valid bits are cleared on completion.
- Reset mid-refill: FSM returns to IDLE, valids cleared, mem_req_valid_o=0 the next cycle. The backing memory is reset by the same rst_i.
- Tag and data writes occur only on the final-word edge and the response edges respectively. No partial line is ever reported as a hit.

Optional Feature:
Macro ICACHE_PERF_COUNTERS_EN.
- Defined: adds outputs hit_count_o[31:0] and miss_count_o[31:0], both reset to 0 and wrapping at 2^32.
  - hit_count_o increments on each cycle with hit=1.
  - miss_count_o increments on each IDLE->REQUEST transition. A stall held across one refill counts once.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, read_address_i=0x100, ready=1, responses 0xA0..0xA3 on consecutive cycles -> mem_req_address_o=0x100 in cycle 1; read_valid_o=1, read_data_o=0xA0 in cycle 6; address 0x10C -> 0xA3 with no new request.
- Conflict: after filling 0x000, read 0x400 (same index, defaults) -> new request to 0x400, refill. Re-reading 0x000 misses again.
- Backpressure: hold mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o and address stable, stall_o=1 throughout; hit arrives 5 cycles later than the cold-miss case.
- Invalidate: line 0x100 valid, pulse invalidate_i in IDLE -> next cycle read 0x100 misses. Pulse during REFILL -> refill completes, line still misses afterwards.
- Reset mid-refill: assert rst_i after 2 response words -> next cycle mem_req_valid_o=0, state IDLE, read of 0x100 misses and issues a fresh request.
- Perf (ICACHE_PERF_COUNTERS_EN): cold miss then 3 hit cycles -> miss_count_o=1, hit_count_o=3.
